// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arbiter_pkg;

  localparam int   DATA_W_DEF = 32;
  localparam logic PORT_CPU   = 1'b0;
  localparam logic PORT_DMA   = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  function automatic logic [1:0] port_onehot(input logic port);
    return (port == PORT_DMA) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on a tie the port not served last wins.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  always_comb begin
    gnt_valid = |valid;
    if (valid == 2'b11) gnt_idx = ~last_grant;
    else                gnt_idx = valid[1] & ~valid[0];
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and one-cycle access sequencer in front of a single-port
// data memory, with a registered valid/ready response back to the granted port.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MEM_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic              req_we0,
  input  logic              req_we1,
  input  logic [31:0]       req_addr0,
  input  logic [31:0]       req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_we,
  output logic              mem_re,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [31:0] ADDR_LIMIT = 32'(4 * MEM_WORDS);

  state_e              state_q, state_d;
  logic                last_grant_q;
  logic                port_q, we_q, err_q;
  logic [31:0]         addr_q;
  logic [DATA_W-1:0]   wdata_q, rdata_q;

  logic                gnt_valid, gnt_idx;
  logic                sel_we, sel_err, accept;
  logic [31:0]         sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  rr_arb2 u_arb (
    .valid      (req_valid),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx)
  );

  assign sel_we    = gnt_idx ? req_we1    : req_we0;
  assign sel_addr  = gnt_idx ? req_addr1  : req_addr0;
  assign sel_wdata = gnt_idx ? req_wdata1 : req_wdata0;
  assign sel_err   = (sel_addr[1:0] != 2'b00) || (sel_addr >= ADDR_LIMIT);
  assign accept    = |req_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // req_ready is masked by reset_n so nothing is offered while reset is held
  always_comb begin
    state_d   = state_q;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_valid && reset_n) begin
          req_ready = port_onehot(gnt_idx);
          state_d   = sel_err ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        mem_we  = we_q;
        mem_re  = ~we_q;
        state_d = RESP;
      end
      RESP: begin
        rsp_valid = port_onehot(port_q);
        if (rsp_ready[port_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= PORT_DMA;
      port_q       <= PORT_CPU;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else if (accept) begin
      last_grant_q <= gnt_idx;
      port_q       <= gnt_idx;
      we_q         <= sel_we;
      err_q        <= sel_err;
      addr_q       <= sel_addr;
      wdata_q      <= sel_wdata;
      rdata_q      <= '0;
    end else if (state_q == ACCESS) begin
      rdata_q      <= we_q ? '0 : mem_rdata;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a memory model, a request driver and a
// response monitor that pops expected results in acceptance order.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int DW = 32;
  localparam int MW = 256;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic          req_we0, req_we1, rsp_err, mem_we, mem_re;
  logic [31:0]   req_addr0, req_addr1, mem_addr;
  logic [DW-1:0] req_wdata0, req_wdata1, rsp_rdata, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_W(DW), .MEM_WORDS(MW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we0(req_we0), .req_we1(req_we1),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // memory model: combinational read, write on the rising edge
  logic [DW-1:0] mem [MW];
  int            we_cnt = 0, re_cnt = 0, cyc = 0;
  logic [31:0]   last_we_addr = '0;

  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) begin
      mem[mem_addr[9:2]] <= mem_wdata;
      we_cnt             <= we_cnt + 1;
      last_we_addr       <= mem_addr;
    end
    if (mem_re) re_cnt <= re_cnt + 1;
  end

  typedef struct {
    logic          port;
    logic [DW-1:0] rdata;
    logic          err;
    int            acc;
  } exp_t;

  exp_t          q[$];
  logic          glog[$];
  logic [DW-1:0] ref_mem [MW];
  int            last_acc [2];
  int            checks = 0, errors = 0;
  bit            seen = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // drive one request on port p; returns 1ns after the accepting edge
  task automatic issue(input int p, input logic we, input logic [31:0] addr, input logic [DW-1:0] wd);
    exp_t e;
    int   n = 0;
    if (p == 0) begin req_we0 = we; req_addr0 = addr; req_wdata0 = wd; end
    else        begin req_we1 = we; req_addr1 = addr; req_wdata1 = wd; end
    req_valid[p] = 1'b1;
    do begin @(negedge clk); n++; end while (!req_ready[p] && n < 100);
    if (!req_ready[p]) begin
      chk("accept_tmo", {63'b0, req_ready[p]}, 64'd1);
      req_valid[p] = 1'b0;
      return;
    end
    e.acc = cyc;
    last_acc[p] = cyc;
    @(posedge clk);
    e.port = p[0];
    e.err  = (addr[1:0] != 2'b00) || (addr >= 32'(4 * MW));
    if (e.err) e.rdata = '0;
    else if (we) begin ref_mem[addr[9:2]] = wd; e.rdata = '0; end
    else e.rdata = ref_mem[addr[9:2]];
    q.push_back(e);
    glog.push_back(p[0]);
    #1 req_valid[p] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || rsp_valid != 2'b00) && n < 200) begin @(negedge clk); n++; end
    if (q.size() != 0) chk("drain_tmo", 64'(q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  // response monitor: content and latency checked on first visibility
  initial forever begin
    @(negedge clk);
    if (reset_n && rsp_valid != 2'b00) begin
      if (!seen) begin
        if (q.size() == 0) chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
        else begin
          chk("rsp_port",  64'(rsp_valid), q[0].port ? 64'd2 : 64'd1);
          chk("rsp_lat",   64'(cyc - q[0].acc), q[0].err ? 64'd1 : 64'd2);
          chk("rsp_rdata", 64'(rsp_rdata), 64'(q[0].rdata));
          chk("rsp_err",   64'(rsp_err), 64'(q[0].err));
        end
        seen = 1'b1;
      end
      if ((rsp_valid & rsp_ready) != 2'b00) begin
        if (q.size() != 0) void'(q.pop_front());
        seen = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int w0, r0, stall_cyc;
    for (int i = 0; i < MW; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    reset_n = 1'b0; rsp_ready = 2'b11;
    req_we0 = 1'b0; req_we1 = 1'b0; req_addr0 = 32'h0; req_addr1 = 32'h4;
    req_wdata0 = '0; req_wdata1 = '0;
    req_valid = 2'b11;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_rsp_err",   64'(rsp_err),   64'd0);
    chk("rst_mem_en",    64'({mem_we, mem_re}), 64'd0);
    chk("rst_mem_addr",  64'(mem_addr),  64'd0);
    req_valid = 2'b00;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // both ports busy: CPU stores, DMA loads the same words back
    glog.delete();
    fork
      begin for (int i = 0; i < 10; i++) issue(0, 1'b1, 32'(i * 4) + 32'h100, 32'hA000_0000 + 32'(i)); end
      begin for (int i = 0; i < 10; i++) issue(1, 1'b0, 32'(i * 4) + 32'h100, '0); end
    join
    drain();
    chk("rr_count", 64'(glog.size()), 64'd20);
    for (int i = 0; i < glog.size(); i++) chk("rr_order", 64'(glog[i]), 64'(i % 2));

    // store then load through port 0
    w0 = we_cnt; r0 = re_cnt;
    issue(0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    drain();
    chk("st_we_pulses", 64'(we_cnt - w0), 64'd1);
    chk("st_we_addr",   64'(last_we_addr), 64'h10);
    issue(0, 1'b0, 32'h10, '0);
    drain();
    chk("ld_re_pulses", 64'(re_cnt - r0), 64'd1);

    // rejected requests never touch memory
    w0 = we_cnt; r0 = re_cnt;
    issue(0, 1'b0, 32'h13, '0);
    issue(0, 1'b0, 32'h400, '0);
    issue(1, 1'b1, 32'h2, 32'h5);
    drain();
    chk("err_no_we", 64'(we_cnt - w0), 64'd0);
    chk("err_no_re", 64'(re_cnt - r0), 64'd0);

    // response back-pressure on port 0 while port 1 waits
    rsp_ready = 2'b10;
    issue(0, 1'b0, 32'h10, '0);
    for (int n = 0; n < 10 && !rsp_valid[0]; n++) @(negedge clk);
    chk("stall_seen", 64'(rsp_valid), 64'd1);
    stall_cyc = 0;
    fork
      issue(1, 1'b0, 32'h104, '0);
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("stall_valid", 64'(rsp_valid), 64'd1);
          chk("stall_rdata", 64'(rsp_rdata), 64'(ref_mem[4]));
          chk("stall_ready", 64'(req_ready), 64'd0);
        end
        stall_cyc = cyc;
        @(posedge clk); #1 rsp_ready = 2'b11;
      end
    join
    drain();
    chk("stall_dma_after", 64'(last_acc[1] > stall_cyc), 64'd1);

    // async reset while a load is in ACCESS
    issue(0, 1'b0, 32'h10, '0);
    chk("pre_rst_mem_re", 64'(mem_re), 64'd1);
    q.delete(); seen = 1'b0;
    req_addr0 = 32'h100; req_addr1 = 32'h104; req_we0 = 1'b0; req_we1 = 1'b0;
    req_valid = 2'b11;
    reset_n = 1'b0;
    #1;
    chk("arst_mem_en",    64'({mem_we, mem_re}), 64'd0);
    chk("arst_mem_addr",  64'(mem_addr), 64'd0);
    chk("arst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("arst_rsp",       64'({rsp_valid, rsp_err}), 64'd0);
    chk("arst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("arst_req_ready", 64'(req_ready), 64'd0);
    req_valid = 2'b00;
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;
    glog.delete();
    fork
      issue(0, 1'b0, 32'h100, '0);
      issue(1, 1'b0, 32'h104, '0);
    join
    drain();
    chk("arst_tie_first", 64'(glog[0]), 64'(PORT_CPU));

    // last word: DMA stores, CPU reads it back
    issue(1, 1'b1, 32'h3FC, 32'h55);
    issue(0, 1'b0, 32'h3FC, '0);
    drain();
    chk("last_word_mem", 64'(mem[MW-1]), 64'h55);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer in front of the single-port data memory. It accepts load/store requests from the CPU load/store unit (port 0) and the DMA/debug loader (port 1), grants one at a time with round-robin fairness, and drives the memory's write/read enables, address and write data for exactly one cycle per access. It captures the combinational read data into a response register and returns it to the granted requester over a valid/ready response handshake.

## Interface
- DATA_W, 32: data width; equals memory word width
- MEM_WORDS, 256: memory depth in words; legal byte address range 0 .. 4*MEM_WORDS-1
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  2  per-port request valid (bit 0 CPU, bit 1 DMA)
- req_ready  out  2  per-port request accept; at most one bit high
- req_we0 / req_we1  in  1  1 = store, 0 = load
- req_addr0 / req_addr1  in  32  byte address
- req_wdata0 / req_wdata1  in  DATA_W  store data
- rsp_valid  out  2  per-port response valid; at most one bit high
- rsp_ready  in  2  per-port response accept
- rsp_rdata  out  DATA_W  load data (0 for stores and errors)
- rsp_err  out  1  1 = request rejected (misaligned or out of range)
- mem_we  out  1  to memory write enable
- mem_re  out  1  to memory read enable
- mem_addr  out  32  to memory address
- mem_wdata  out  DATA_W  to memory write data
- mem_rdata  in  DATA_W  from memory, combinational read data

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state IDLE.
- IDLE: grant = round-robin over req_valid; if both valid, the port not served last wins; last_grant resets to 1, so port 0 wins the first tie. req_ready[grant] = 1 only in IDLE. On handshake: latch port id, we, addr, wdata; update last_grant; go to ACCESS.
- Error check at acceptance: addr[1:0] != 0 or addr >= 4*MEM_WORDS sets err_q. Erroneous requests skip memory (no mem_we/mem_re) and go directly to RESP with rsp_err=1, rsp_rdata=0.
- ACCESS (one cycle): mem_addr/mem_wdata = latched values; mem_we = we_q; mem_re = !we_q. rdata_q <= mem_rdata if load, else 0. Go to RESP.
- RESP: rsp_valid[port_q] = 1, rsp_rdata = rdata_q, rsp_err = err_q, all held stable until rsp_ready[port_q]; then return to IDLE. rsp_ready on the other port is ignored.
- Outside ACCESS: mem_we = mem_re = 0; mem_addr/mem_wdata hold latched values (don't care).
- Requester may drop req_valid before acceptance without effect; requests are not queued.

## Timing
- Reset (async, any state): state IDLE, req_ready = 0 during reset, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, mem_we = mem_re = 0, mem_addr = 0, mem_wdata = 0, last_grant = 1. An in-flight access is abandoned; a store in ACCESS at reset assertion may or may not commit.
- Accept at edge N -> ACCESS in cycle N..N+1 -> rsp_valid visible after edge N+2. Error path: rsp_valid after edge N+1.
- Minimum issue interval 3 cycles (2 for errors); with rsp_ready tied high, back-to-back ports alternate.
- A store followed by a load to the same address from either port returns the stored data (sequential, no bypass needed).
- req_ready is combinational from req_valid and state; no combinational path from rsp_ready to req_ready within the same cycle (IDLE is entered only on the next edge).

## Structure
- Shared package: state enum (IDLE/ACCESS/RESP), port index constants PORT_CPU=0, PORT_DMA=1, DATA_W default.
- One natural sub-module: rr_arb2 (2-way round-robin grant from valid vector and last_grant). Everything else in dmem_arbiter.

## Test plan
- Reset release, port 0 store 0xDEADBEEF to 0x10, then load 0x10 -> mem_we pulses once with mem_addr=0x10; load response rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid 2 cycles after accept.
- Both ports valid continuously, rsp_ready=11 -> grants alternate 0,1,0,1; first grant to port 0; no starvation over 20 requests.
- Load from 0x13 (misaligned) and 0x400 (out of range) -> no mem_re/mem_we, rsp_err=1, rsp_rdata=0, response 1 cycle after accept.
- rsp_ready held 0 for 5 cycles in RESP -> rsp_valid/rsp_rdata stable, req_ready stays 00, other port's request accepted only after rsp_ready handshake.
- reset_n asserted during ACCESS -> all outputs zero immediately (async); after release FSM in IDLE and first tie goes to port 0.
- Port 1 store 0x55 to 0x3FC (last word), port 0 loads 0x3FC -> rsp_rdata=0x55 on rsp_valid[0] only.
